// File: rtl/ahb_arb_pkg.sv
// Shared types and helpers for the AHB-lite multi-master arbiter.
// DEF_ADDR_WIDTH / DEF_DATA_WIDTH set the default bus widths.
package ahb_arb_pkg;

  localparam int MAX_MASTERS = 4;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEQ = 2'd2,
    SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } hburst_e;

  typedef enum logic {
    PARK  = 1'b0,
    OWNED = 1'b1
  } arb_state_e;

  // Remaining beats after the NONSEQ; undefined-length bursts count as zero.
  function automatic logic [3:0] burst_beats(input logic [2:0] hburst);
    logic [3:0] beats;
    case (hburst_e'(hburst))
      WRAP4, INCR4:   beats = 4'd3;
      WRAP8, INCR8:   beats = 4'd7;
      WRAP16, INCR16: beats = 4'd15;
      default:        beats = 4'd0;
    endcase
    return beats;
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [MAX_MASTERS-1:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < MAX_MASTERS; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ahb_arb_rr_pick.sv
// Combinational round-robin selector: first requester after rr_ptr, wrapping,
// with rr_ptr itself considered last so a lone owner keeps the bus.
module ahb_arb_rr_pick #(
  parameter int NUM_MASTERS = 4
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [1:0]             rr_ptr,
  output logic [NUM_MASTERS-1:0] gnt,
  output logic                   valid
);

  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      for (int j = 0; j < NUM_MASTERS; j++) begin
        if (!found && req[j] && (j == ((int'(rr_ptr) + k) % NUM_MASTERS))) begin
          gnt[j] = 1'b1;
          found  = 1'b1;
        end
      end
    end
    valid = found;
  end

endmodule

// File: rtl/ahb_arb_ctrl.sv
// AHB-lite multi-master arbiter and bus sequencer with round-robin grant.
// Define AHB_ARB_LOCK_EN to add m_hlock / hmastlock locked-transfer support.
module ahb_arb_ctrl
  import ahb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH
) (
  input  logic                             hclk,
  input  logic                             hreset,
  input  logic [NUM_MASTERS-1:0]           m_hbusreq,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_haddr,
  input  logic [NUM_MASTERS*2-1:0]         m_htrans,
  input  logic [NUM_MASTERS-1:0]           m_hwrite,
  input  logic [NUM_MASTERS*3-1:0]         m_hsize,
  input  logic [NUM_MASTERS*3-1:0]         m_hburst,
  input  logic [NUM_MASTERS*4-1:0]         m_hprot,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_hwdata,
  output logic [NUM_MASTERS-1:0]           hgrant,
  output logic [1:0]                       hmaster,
  output logic                             hsel,
  output logic [ADDR_WIDTH-1:0]            haddr,
  output logic [1:0]                       htrans,
  output logic                             hwrite,
  output logic [2:0]                       hsize,
  output logic [2:0]                       hburst,
  output logic [3:0]                       hprot,
  output logic [DATA_WIDTH-1:0]            hwdata,
  input  logic                             hready,
`ifdef AHB_ARB_LOCK_EN
  input  logic [NUM_MASTERS-1:0]           m_hlock,
  output logic                             hmastlock,
`endif
  output arb_state_e                       dbg_state,
  output logic [3:0]                       dbg_beat_cnt
);

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [1:0]             hmaster_q, hmaster_d;
  logic [1:0]             data_master_q, data_master_d;
  logic [1:0]             rr_ptr_q, rr_ptr_d;
  logic [3:0]             beat_cnt_q, beat_cnt_d;

  logic                   own_req;
  logic                   own_lock;
  logic                   arb_ok;
  logic [NUM_MASTERS-1:0] pick_gnt;
  logic                   pick_valid;
  logic [MAX_MASTERS-1:0] pick_gnt_w;

  ahb_arb_rr_pick #(
    .NUM_MASTERS(NUM_MASTERS)
  ) u_rr_pick (
    .req   (m_hbusreq),
    .rr_ptr(rr_ptr_q),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  // State register
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q       <= PARK;
      grant_q       <= NUM_MASTERS'(1);
      hmaster_q     <= 2'd0;
      data_master_q <= 2'd0;
      rr_ptr_q      <= 2'd0;
      beat_cnt_q    <= 4'd0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      hmaster_q     <= hmaster_d;
      data_master_q <= data_master_d;
      rr_ptr_q      <= rr_ptr_d;
      beat_cnt_q    <= beat_cnt_d;
    end
  end

  // Next-state: arbitration point, grant selection and burst tracking
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    hmaster_d     = hmaster_q;
    data_master_d = data_master_q;
    rr_ptr_d      = rr_ptr_q;
    beat_cnt_d    = beat_cnt_q;
    pick_gnt_w    = '0;
    pick_gnt_w[NUM_MASTERS-1:0] = pick_gnt;

    arb_ok = hready && (!own_req || (htrans == IDLE) ||
                        ((beat_cnt_q == 4'd0) && (htrans != SEQ)));
    if (own_lock) arb_ok = 1'b0;

    if (hready) begin
      data_master_d = hmaster_q;
      if (htrans == NONSEQ) begin
        beat_cnt_d = burst_beats(hburst);
      end else if ((htrans == SEQ) && (beat_cnt_q != 4'd0)) begin
        beat_cnt_d = beat_cnt_q - 4'd1;
      end
    end

    if (arb_ok) begin
      if (pick_valid) begin
        state_d   = OWNED;
        grant_d   = pick_gnt;
        hmaster_d = onehot_idx(pick_gnt_w);
        rr_ptr_d  = onehot_idx(pick_gnt_w);
      end else begin
        // Nobody wants the bus: park on the default master, keep rr_ptr.
        state_d   = PARK;
        grant_d   = NUM_MASTERS'(1);
        hmaster_d = 2'd0;
      end
    end
  end

  // Outputs: address phase from hmaster, write data from the data-phase owner
  always_comb begin
    haddr    = '0;
    htrans   = IDLE;
    hwrite   = 1'b0;
    hsize    = 3'd0;
    hburst   = 3'd0;
    hprot    = 4'd0;
    hwdata   = '0;
    own_req  = 1'b0;
    own_lock = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (hmaster_q == 2'(i)) begin
        haddr   = m_haddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        htrans  = m_htrans[i*2 +: 2];
        hwrite  = m_hwrite[i];
        hsize   = m_hsize[i*3 +: 3];
        hburst  = m_hburst[i*3 +: 3];
        hprot   = m_hprot[i*4 +: 4];
        own_req = m_hbusreq[i];
`ifdef AHB_ARB_LOCK_EN
        own_lock = m_hlock[i];
`endif
      end
      if (data_master_q == 2'(i)) begin
        hwdata = m_hwdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    hsel         = (htrans != IDLE);
    hgrant       = grant_q;
    hmaster      = hmaster_q;
    dbg_state    = state_q;
    dbg_beat_cnt = beat_cnt_q;
`ifdef AHB_ARB_LOCK_EN
    hmastlock    = own_lock;
`endif
  end

endmodule

// File: doc/ahb_arb_ctrl.md
# ahb_arb_ctrl

Multi-master arbiter and bus sequencer that shares the single AHB-lite slave port between NUM_MASTERS requesting masters. It grants the bus round-robin and changes ownership only at legal boundaries: bus idle, master released, or end of a fixed-length burst. It multiplexes the owner's address/control and write data onto the shared slave signals and tracks the data-phase owner separately from the address-phase owner. It sits between the bench's master agents and the slave DUT, in place of a direct single-master connection.

## Interface
- NUM_MASTERS, 4: number of requesters; legal values are 2 to 4.
- ADDR_WIDTH, `ADDR_WIDTH: address width.
- DATA_WIDTH, `DATA_WIDTH: data width.
- hclk  input  1  bus clock; all state changes on its rising edge.
- hreset  input  1  reset; **one clock, reset synchronous active-high**, sampled on the rising edge of hclk.
- m_hbusreq  input  NUM_MASTERS  per-master bus request.
- m_haddr  input  NUM_MASTERS*ADDR_WIDTH  flattened per-master address; master i occupies slice i.
- m_htrans  input  NUM_MASTERS*2  per-master transfer type.
- m_hwrite  input  NUM_MASTERS  per-master write flag.
- m_hsize  input  NUM_MASTERS*3  per-master size.
- m_hburst  input  NUM_MASTERS*3  per-master burst type.
- m_hprot  input  NUM_MASTERS*4  per-master protection.
- m_hwdata  input  NUM_MASTERS*DATA_WIDTH  per-master write data.
- hgrant  output  NUM_MASTERS  one-hot grant.
- hmaster  output  2  index of the address-phase owner.
- hsel, haddr, htrans, hwrite, hsize, hburst, hprot  output  1/ADDR_WIDTH/2/1/3/3/4  muxed address phase to the slave.
- hwdata  output  DATA_WIDTH  write data of the data-phase owner.
- hready  input  1  transfer-complete signal from the slave's hreadyout; also broadcast back to the masters.

## Operation
- States:
  - PARK: no owner; grant sits on master 0, the default master, which must drive IDLE.
  - OWNED: one master holds the bus.
- Re-arbitration point (ARB_OK) is true when hready=1 and at least one of these holds:
  - the owner's hbusreq=0;
  - the owner's htrans is IDLE;
  - beat_cnt==0 and the owner's htrans is not SEQ.
- At a rising edge with ARB_OK, the next owner is the first requesting master found by scanning from rr_ptr+1, wrapping modulo NUM_MASTERS.
  - rr_ptr is updated to the new owner.
  - If no master is requesting: go to PARK and grant master 0. rr_ptr is unchanged.
  - If the current owner is the only requester, it keeps the grant.
- Beat counter:
  - Loaded on an accepted NONSEQ (hready=1) with length-1: 3, 7 or 15 for INCR4/WRAP4, INCR8/WRAP8, INCR16/WRAP16; 0 for SINGLE and INCR.
  - Decremented on each accepted SEQ; saturates at 0.
  - BUSY and IDLE do not change it.
- An INCR (undefined-length) burst can be broken at any ARB_OK point.
- Output muxing:
  - Address phase is taken from master hmaster.
  - hsel = (muxed htrans != IDLE).
  - hwdata is taken from data_master, which is loaded with hmaster on every rising edge with hready=1.
- hready=0 freezes hgrant, hmaster, data_master, beat_cnt and rr_ptr.

## Timing
- Reset values:
  - hgrant = 1 (one-hot, master 0), hmaster = 0, data_master = 0, rr_ptr = 0, beat_cnt = 0, state PARK.
  - Muxed outputs follow master 0; hsel = 0 once master 0 drives IDLE.
- hreset asserted mid-burst aborts the burst; the above values apply at the next edge.
- Latency: a request asserted in cycle N, with the bus parked and hready=1, gives hgrant/hmaster updated after edge N+1. The master then drives NONSEQ in the following cycle.
- hgrant and hmaster change on the same edge; data_master lags hmaster by exactly one accepted transfer.
- Simultaneous requests are resolved by round-robin order only. No master waits more than NUM_MASTERS-1 ownership tenures.
- Address and write-data muxes are combinational from registered selects. There is no added latency on slave-bound signals.

## Configuration
- AHB_ARB_LOCK_EN defined:
  - Adds input m_hlock [NUM_MASTERS] and output hmastlock (1 bit).
  - While the owner's hlock=1, ARB_OK is forced false.
  - hmastlock = the owner's hlock, muxed with the address phase.
  - hlock falling releases the bus at the next ARB_OK.
- Not defined: no hlock ports, no hmastlock port, and arbitration is as above.

## Structure
- Package ahb_arb_pkg holds:
  - htrans_e (IDLE, BUSY, NONSEQ, SEQ);
  - hburst_e (SINGLE through INCR16);
  - the function burst_beats(hburst) returning length-1;
  - MAX_MASTERS = 4.
- Sub-module ahb_arb_rr_pick: combinational round-robin selector. Inputs are req and rr_ptr; outputs are a one-hot grant and a valid flag.

## Test plan
- Reset with no requests -> hgrant=4'b0001, hmaster=0, hsel=0 after the first post-reset edge.
- m_hbusreq=4'b0110 simultaneously from park with hready=1 -> master 1 granted, then master 2 on master 1's release; rr_ptr wraps correctly.
- Master 2 runs INCR8 while master 3 requests from beat 2 -> hmaster stays 2 until the 8th beat is accepted, then switches to 3.
- hready held 0 for 3 cycles mid-WRAP4 with a competing request -> all grant state frozen; beat_cnt resumes at the same value.
- Write from master 1 followed by master 0 handover -> hwdata comes from master 1 during its data phase while haddr comes from master 0.
- With AHB_ARB_LOCK_EN defined, master 0 holds hlock=1 across two INCR4 bursts while master 1 requests -> no handover and hmastlock=1; handover occurs at the first ARB_OK after hlock falls.
